// File: rtl/dunc_phase_sequencer.sv
// dunc_phase_sequencer: one-hot phase ring, FETCH/EXECUTE/EXECUTE2/HALT major
// state, store write strobes and a retired-instruction counter.
// Build option: DUNC_WAIT_EN -- when defined, MEM_RDY low at T[MEM_PHASE]
// holds the ring (STALL); when undefined, MEM_RDY is ignored and the ring
// advances every CLK.
module dunc_phase_sequencer #(
  parameter int PHASES    = 4,
  parameter int MEM_PHASE = 1,
  parameter int SET_PHASE = 1,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_RDY,
  input  logic              I_STORE,
  input  logic              I_LONG,
  input  logic              HALT_REQ,
  output logic [PHASES-1:0] T,
  output logic              FETCH,
  output logic              EXECUTE,
  output logic              SETWRITE,
  output logic              CLRWRITE,
  output logic              WRITE,
  output logic              DO_WRITE,
  output logic              STALL,
  output logic              HALTED,
  output logic [CNT_W-1:0]  RETIRED
);

  // Elaboration-time parameter legality.
  generate
    if (PHASES < 3 || PHASES > 16) begin : g_bad_phases
      $error("dunc_phase_sequencer: PHASES must be 3..16");
    end
    if (MEM_PHASE < 0 || MEM_PHASE >= PHASES) begin : g_bad_mem_phase
      $error("dunc_phase_sequencer: MEM_PHASE must be < PHASES");
    end
    if (SET_PHASE < 0 || SET_PHASE >= PHASES - 1) begin : g_bad_set_phase
      $error("dunc_phase_sequencer: SET_PHASE must be < PHASES-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PHASES-1:0]  r_t;
  logic [PHASES-1:0]  w_t_nxt;
  logic               r_write;
  logic [CNT_W-1:0]   r_retired;

  logic w_fetch;
  logic w_exec;
  logic w_last;
  logic w_stall;
  logic w_final;
  logic w_setwrite;
  logic w_clrwrite;
  logic w_retire;

  assign w_fetch = (r_state == S_FETCH);
  assign w_exec  = (r_state == S_EXEC) || (r_state == S_EXEC2);
  assign w_last  = r_t[PHASES-1];

`ifdef DUNC_WAIT_EN
  assign w_stall = r_t[MEM_PHASE] & ~MEM_RDY & (w_fetch | w_exec);
`else
  // Fixed-timing build: memory is assumed always ready.
  logic w_unused_mem_rdy;
  assign w_unused_mem_rdy = MEM_RDY;
  assign w_stall          = 1'b0;
`endif

  // Final pass: a short instruction's only pass, or the second pass of a long one.
  assign w_final    = ((r_state == S_EXEC) & ~I_LONG) | (r_state == S_EXEC2);
  assign w_setwrite = (r_state == S_EXEC) & I_STORE & r_t[SET_PHASE] & ~w_stall;
  assign w_clrwrite = w_final & w_last & r_write & ~w_stall;

  // Next phase / major state; retire happens on the unstalled last phase of the final pass.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_retire    = 1'b0;
    case (r_state)
      S_HALT: begin
        if (!HALT_REQ) w_state_nxt = S_FETCH;
      end
      default: begin
        if (!w_stall) begin
          w_t_nxt = {r_t[PHASES-2:0], r_t[PHASES-1]};
          if (w_last) begin
            case (r_state)
              S_FETCH: w_state_nxt = S_EXEC;
              S_EXEC: begin
                if (I_LONG) w_state_nxt = S_EXEC2;
                else        w_retire    = 1'b1;
              end
              default: w_retire = 1'b1;
            endcase
          end
        end
      end
    endcase
    // Halt is only taken at an instruction boundary.
    if (w_retire) w_state_nxt = HALT_REQ ? S_HALT : S_FETCH;
  end

  // Major state and phase ring registers; ring wraps to T0 whenever HALT is entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_FETCH;
      r_t     <= {{(PHASES-1){1'b0}}, 1'b1};
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Write-pending flag; clear has priority over set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          r_write <= 1'b0;
    else if (w_clrwrite) r_write <= 1'b0;
    else if (w_setwrite) r_write <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign T        = r_t;
  assign FETCH    = w_fetch;
  assign EXECUTE  = w_exec;
  assign SETWRITE = w_setwrite;
  assign CLRWRITE = w_clrwrite;
  assign WRITE    = r_write;
  assign DO_WRITE = r_write & r_t[MEM_PHASE] & ~w_stall;
  assign STALL    = w_stall;
  assign HALTED   = (r_state == S_HALT);
  assign RETIRED  = r_retired;

endmodule
